dot_seq_accum: RTL and testbench

- Initiator/feeder for the 4-lane parallel dot-product unit.
- On `start`, streams a row of length 4·`len` from dual-read weight/input memories into the 4-lane multiply-sum datapath, one group of four elements per cycle.
- Collects each 4-lane partial sum after the fixed datapath latency and accumulates it into a wide signed accumulator.
- Delivers a saturated 16-bit dot product with a `done` pulse. Used by GRU/LSTM gate units for matrix-vector rows.

---
 rtl/dot_seq_accum.sv | 146 ++++++++++++++
 tb/tb_dot_seq_accum.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dot_seq_accum.sv
// dot_seq_accum: feeds a 4-lane dot-product datapath from dual-read memories and accumulates saturated row sums
// Ports:
//   clk, rst_n                    clock (rising edge), asynchronous active-low reset
//   i_start, i_len, i_base_addr   row request, group count and first group address (sampled in IDLE)
//   o_rd_en, o_rd_addr            memory read strobe and group address (data returns next cycle)
//   i_rd_a_0..3, i_rd_b_0..3      signed memory operands
//   o_mac_en, o_mac_a/b_0..3      datapath enable and operand pass-through
//   i_mac_valid, i_mac_sum        datapath result valid and signed 4-lane partial sum
//   o_busy, o_done                not-IDLE flag and one-cycle completion pulse
//   o_dot_out, o_sat, o_err       saturated result, clip flag, sticky missing-valid flag
module dot_seq_accum #(
    parameter int ADDR_W   = 8,
    parameter int MULT_LAT = 3,
    parameter int ACC_W    = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic [ADDR_W-1:0]        i_len,
    input  logic [ADDR_W-1:0]        i_base_addr,
    output logic                     o_rd_en,
    output logic [ADDR_W-1:0]        o_rd_addr,
    input  logic signed [15:0]       i_rd_a_0,
    input  logic signed [15:0]       i_rd_a_1,
    input  logic signed [15:0]       i_rd_a_2,
    input  logic signed [15:0]       i_rd_a_3,
    input  logic signed [15:0]       i_rd_b_0,
    input  logic signed [15:0]       i_rd_b_1,
    input  logic signed [15:0]       i_rd_b_2,
    input  logic signed [15:0]       i_rd_b_3,
    output logic                     o_mac_en,
    output logic signed [15:0]       o_mac_a_0,
    output logic signed [15:0]       o_mac_a_1,
    output logic signed [15:0]       o_mac_a_2,
    output logic signed [15:0]       o_mac_a_3,
    output logic signed [15:0]       o_mac_b_0,
    output logic signed [15:0]       o_mac_b_1,
    output logic signed [15:0]       o_mac_b_2,
    output logic signed [15:0]       o_mac_b_3,
    input  logic                     i_mac_valid,
    input  logic signed [15:0]       i_mac_sum,
    output logic                     o_busy,
    output logic                     o_done,
    output logic signed [15:0]       o_dot_out,
    output logic                     o_sat,
    output logic                     o_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-32768);

    state_t                   r_state, w_state_nxt;
    logic [ADDR_W-1:0]        r_len, r_base, r_issue_cnt, r_take_cnt;
    logic                     r_mac_en;
    logic [MULT_LAT-1:0]      r_tok;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [15:0]       r_dot;
    logic                     r_sat, r_err;

    logic                     w_accept, w_pop, w_hi, w_lo;
    logic signed [ACC_W-1:0]  w_sum_ext, w_acc_nxt;
    logic signed [15:0]       w_dot;

    assign o_mac_a_0 = i_rd_a_0;
    assign o_mac_a_1 = i_rd_a_1;
    assign o_mac_a_2 = i_rd_a_2;
    assign o_mac_a_3 = i_rd_a_3;
    assign o_mac_b_0 = i_rd_b_0;
    assign o_mac_b_1 = i_rd_b_1;
    assign o_mac_b_2 = i_rd_b_2;
    assign o_mac_b_3 = i_rd_b_3;
    assign o_mac_en  = r_mac_en;
    assign o_dot_out = r_dot;
    assign o_sat     = r_sat;
    assign o_err     = r_err;

    // a token leaving the delay line marks the cycle its partial sum is on i_mac_sum
    assign w_accept  = (r_state == IDLE) && i_start;
    assign w_pop     = r_tok[MULT_LAT-1];
    assign w_sum_ext = {{(ACC_W-16){i_mac_sum[15]}}, i_mac_sum};
    assign w_acc_nxt = w_accept ? '0 : w_pop ? r_acc + w_sum_ext : r_acc;
    // clip the value the accumulator holds on entry to FIN so the result is visible with done
    assign w_hi      = w_acc_nxt > ACC_MAX;
    assign w_lo      = w_acc_nxt < ACC_MIN;
    assign w_dot     = w_hi ? 16'sh7fff : w_lo ? 16'sh8000 : w_acc_nxt[15:0];

    always_comb begin
        w_state_nxt = r_state;
        o_rd_en     = 1'b0;
        o_rd_addr   = '0;
        o_busy      = r_state != IDLE;
        o_done      = 1'b0;
        case (r_state)
            IDLE:  if (i_start) w_state_nxt = (i_len != '0) ? ISSUE : FIN;
            ISSUE: begin
                o_rd_en   = 1'b1;
                o_rd_addr = r_base + r_issue_cnt;
                if (r_issue_cnt == r_len - ADDR_W'(1)) w_state_nxt = DRAIN;
            end
            DRAIN: if (w_pop && (r_take_cnt + ADDR_W'(1) == r_len)) w_state_nxt = FIN;
            FIN: begin
                o_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_base      <= '0;
            r_issue_cnt <= '0;
            r_take_cnt  <= '0;
            r_mac_en    <= 1'b0;
            r_tok       <= '0;
            r_acc       <= '0;
            r_dot       <= '0;
            r_sat       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mac_en <= o_rd_en;
            r_tok    <= MULT_LAT'({r_tok, r_mac_en});
            r_acc    <= w_acc_nxt;
            if (w_accept) begin
                r_len       <= i_len;
                r_base      <= i_base_addr;
                r_issue_cnt <= '0;
                r_take_cnt  <= '0;
                r_err       <= 1'b0;
                r_sat       <= 1'b0;
            end else begin
                if (o_rd_en) r_issue_cnt <= r_issue_cnt + ADDR_W'(1);
                if (w_pop) r_take_cnt <= r_take_cnt + ADDR_W'(1);
                if (w_pop && !i_mac_valid) r_err <= 1'b1;
            end
            if (w_state_nxt == FIN) begin
                r_dot <= w_dot;
                r_sat <= w_hi | w_lo;
            end
        end
    end
endmodule

// File: tb/tb_dot_seq_accum.sv
// tb_dot_seq_accum: scoreboard bench for dot_seq_accum with memory and 3-stage datapath models
module tb_dot_seq_accum;
    localparam int ML = 3;

    typedef struct {
        logic signed [15:0] dot;
        logic               sat;
        logic               err;
        int                 cyc;
    } exp_t;

    logic clk = 0, rst_n = 0, i_start = 0;
    logic [7:0] i_len = 0, i_base_addr = 0;
    logic o_rd_en, o_mac_en, o_busy, o_done, o_sat, o_err, i_mac_valid;
    logic [7:0] o_rd_addr;
    logic signed [15:0] rd_a[4], rd_b[4], mac_a[4], mac_b[4];
    logic signed [15:0] i_mac_sum, o_dot_out;

    logic signed [15:0] mem_a[256][4], mem_b[256][4];
    logic [16:0] pipe[ML] = '{default: '0};
    int tok_idx = 0, g_drop = -1;
    int g_sum[16];
    exp_t sb[$];
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    dot_seq_accum dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_len(i_len), .i_base_addr(i_base_addr),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
        .i_rd_a_0(rd_a[0]), .i_rd_a_1(rd_a[1]), .i_rd_a_2(rd_a[2]), .i_rd_a_3(rd_a[3]),
        .i_rd_b_0(rd_b[0]), .i_rd_b_1(rd_b[1]), .i_rd_b_2(rd_b[2]), .i_rd_b_3(rd_b[3]),
        .o_mac_en(o_mac_en),
        .o_mac_a_0(mac_a[0]), .o_mac_a_1(mac_a[1]), .o_mac_a_2(mac_a[2]), .o_mac_a_3(mac_a[3]),
        .o_mac_b_0(mac_b[0]), .o_mac_b_1(mac_b[1]), .o_mac_b_2(mac_b[2]), .o_mac_b_3(mac_b[3]),
        .i_mac_valid(i_mac_valid), .i_mac_sum(i_mac_sum),
        .o_busy(o_busy), .o_done(o_done), .o_dot_out(o_dot_out), .o_sat(o_sat), .o_err(o_err)
    );

    // memory returns the addressed group one cycle after the read strobe
    always @(posedge clk)
        if (o_rd_en)
            for (int l = 0; l < 4; l++) begin
                rd_a[l] <= mem_a[o_rd_addr][l];
                rd_b[l] <= mem_b[o_rd_addr][l];
            end

    // datapath: sum of four lane products, valid ML cycles after mac_en; token g_drop comes back invalid
    always @(posedge clk) begin
        int s;
        s = 0;
        for (int l = 0; l < 4; l++) s += int'(mac_a[l]) * int'(mac_b[l]);
        pipe[0] <= {o_mac_en && (tok_idx != g_drop), 16'(s)};
        for (int i = 1; i < ML; i++) pipe[i] <= pipe[i-1];
        tok_idx <= i_start ? 0 : tok_idx + int'(o_mac_en);
    end
    assign i_mac_valid = pipe[ML-1][16];
    assign i_mac_sum   = pipe[ML-1][15:0];

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({o_rd_en, o_rd_addr, o_mac_en, o_busy, o_done, o_dot_out, o_sat, o_err} !== '0)
            $display("FAIL reset_hold: outputs=%h, want all 0", {o_rd_en, o_rd_addr, o_mac_en, o_busy, o_done, o_dot_out, o_sat, o_err});
        else passed++;
        rst_n = 1;
        repeat (2) @(negedge clk);
        total++;
        if ({o_rd_en, o_rd_addr, o_mac_en, o_busy, o_done, o_dot_out, o_sat, o_err} !== '0)
            $display("FAIL reset_idle: outputs=%h, want all 0", {o_rd_en, o_rd_addr, o_mac_en, o_busy, o_done, o_dot_out, o_sat, o_err});
        else passed++;
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        i_start = 1; i_len = 8; i_base_addr = 0;
        @(negedge clk); i_start = 0;
        repeat (2) @(negedge clk);
        total++;
        if (o_rd_en !== 1 || o_busy !== 1) $display("FAIL mid_run_active: rd_en=%b busy=%b, want 1 1", o_rd_en, o_busy);
        else passed++;
        rst_n = 0;
        @(negedge clk);
        total++;
        if ({o_busy, o_rd_en, o_mac_en, o_done} !== 4'b0) $display("FAIL mid_run_reset: busy/rd_en/mac_en/done=%b, want 0000", {o_busy, o_rd_en, o_mac_en, o_done});
        else passed++;
        rst_n = 1;
        repeat (20) begin
            @(negedge clk);
            if (o_done) ndone++;
        end
        total++;
        if (ndone != 0) $display("FAIL mid_run_no_done: done pulses=%0d, want 0", ndone);
        else passed++;
    endtask

    task automatic run_row(input string name, input int len, input int base, input int drop, input bit poke);
        int acc = 0, nrd = 0, nmac = 0, ndone = 0;
        exp_t e, got;
        for (int k = 0; k < len; k++) begin
            int a, x, y;
            a = (base + k) % 256;
            x = $urandom_range(1, 100);
            y = $urandom_range(1, 100);
            mem_a[a][0] = 16'(g_sum[k]); mem_b[a][0] = 1;
            mem_a[a][1] = 16'(x);        mem_b[a][1] = 16'(y);
            mem_a[a][2] = 16'(y);        mem_b[a][2] = 16'(-x);
            mem_a[a][3] = 16'($urandom); mem_b[a][3] = 0;
            acc += g_sum[k];
        end
        e.dot = acc > 32767 ? 16'sh7fff : acc < -32768 ? 16'sh8000 : 16'(acc);
        e.sat = acc > 32767 || acc < -32768;
        e.err = drop >= 0 && drop < len;
        e.cyc = len == 0 ? 1 : len + ML + 2;
        sb.push_back(e);
        g_drop = drop;
        @(negedge clk);
        i_start = 1; i_len = 8'(len); i_base_addr = 8'(base);
        @(negedge clk);
        i_start = 0;
        for (int c = 1; c <= len + ML + 12; c++) begin
            if (poke) i_start = (c == len + 2);
            if (c == 1) begin
                total++;
                if (o_busy !== 1 || o_err !== 0) $display("FAIL %s cycle1: busy=%b err=%b, want 1 0", name, o_busy, o_err);
                else passed++;
            end
            if (o_rd_en) begin
                total++;
                if (o_rd_addr !== 8'(base + nrd) || c != nrd + 1)
                    $display("FAIL %s rd[%0d]: addr=%0d cycle=%0d, want addr=%0d cycle=%0d", name, nrd, o_rd_addr, c, 8'(base + nrd), nrd + 1);
                else passed++;
                nrd++;
            end
            if (o_mac_en) begin
                total++;
                if (c != nmac + 2) $display("FAIL %s mac_en[%0d]: cycle=%0d, want %0d", name, nmac, c, nmac + 2);
                else passed++;
                nmac++;
            end
            if (o_done) begin
                ndone++;
                if (ndone == 1) begin
                    got = sb.pop_front();
                    total++;
                    if (c != got.cyc) $display("FAIL %s done_cycle: got %0d, want %0d", name, c, got.cyc);
                    else passed++;
                    total++;
                    if (o_dot_out !== got.dot) $display("FAIL %s dot_out: got %0d, want %0d", name, o_dot_out, got.dot);
                    else passed++;
                    total++;
                    if (o_sat !== got.sat || o_err !== got.err)
                        $display("FAIL %s sat/err: got %b/%b, want %b/%b", name, o_sat, o_err, got.sat, got.err);
                    else passed++;
                end
            end
            @(negedge clk);
        end
        i_start = 0;
        total++;
        if (nrd != len || nmac != len) $display("FAIL %s counts: rd_en=%0d mac_en=%0d, want %0d", name, nrd, nmac, len);
        else passed++;
        total++;
        if (ndone != 1) $display("FAIL %s done_pulses: got %0d, want 1", name, ndone);
        else passed++;
    endtask

    task automatic test_single();
        g_sum[0] = 100;
        run_row("single", 1, 5, -1, 0);
    endtask

    task automatic test_four();
        g_sum[0] = 1000; g_sum[1] = -250; g_sum[2] = 30000; g_sum[3] = -5;
        run_row("four", 4, 20, -1, 0);
    endtask

    task automatic test_saturation();
        g_sum[0] = 30000; g_sum[1] = 30000; g_sum[2] = -100;
        run_row("sat_pos", 3, 40, -1, 0);
        g_sum[0] = -30000; g_sum[1] = -30000; g_sum[2] = 0;
        run_row("sat_neg", 3, 60, -1, 0);
    endtask

    task automatic test_wrap_and_ignore();
        g_sum[0] = 7; g_sum[1] = -300; g_sum[2] = 1234; g_sum[3] = 55;
        run_row("wrap_ignore", 4, 254, -1, 1);
    endtask

    task automatic test_zero_len();
        run_row("zero_len", 0, 100, -1, 0);
    endtask

    task automatic test_err();
        g_sum[0] = 11; g_sum[1] = 22;
        run_row("err_set", 2, 80, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 12; k++) g_sum[k] = int'($urandom_range(0, 4000)) - 2000;
        run_row("long", 12, 120, -1, 0);
    endtask

    initial begin
        for (int a = 0; a < 256; a++)
            for (int l = 0; l < 4; l++) begin
                mem_a[a][l] = 0;
                mem_b[a][l] = 0;
            end
        test_reset();
        test_reset_mid();
        test_single();
        test_four();
        test_saturation();
        test_wrap_and_ignore();
        test_zero_len();
        test_err();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
